// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port synchronous memory between instruction fetch (IF)
//   and datapath load/store (DP). The round-robin arbiter decides from the
//   current cycle's requests and registers the winner's grant together with
//   the memory command. Read data comes back to the issuing port one cycle
//   after issue, with an rvalid pulse. DP can lock the memory for
//   back-to-back accesses.
//
// Ports
//   clk, rst_n            core clock, synchronous active-low reset
//   if_req/if_addr        fetch read request (held until if_gnt)
//   if_gnt                one-cycle IF grant, coincident with mem_en
//   if_rvalid/if_rdata    IF read return (rdata holds between returns)
//   dp_req/dp_we/dp_lock  datapath request, write select, lock request
//   dp_addr/dp_wdata      datapath address / write data
//   dp_gnt                one-cycle DP grant, coincident with mem_en
//   dp_rvalid/dp_rdata    DP read return (rdata holds between returns)
//   mem_en/mem_we         memory strobe / write enable
//   mem_addr/mem_wdata    memory address / write data (hold when idle)
//   mem_rdata             memory read data, valid the cycle after a read
module mem_port_arbiter #(
    parameter int DATA_RANGE = 8,
    parameter int ADDR_RANGE = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_RANGE-1:0] if_addr,
    output logic                  if_gnt,
    output logic                  if_rvalid,
    output logic [DATA_RANGE-1:0] if_rdata,
    input  logic                  dp_req,
    input  logic                  dp_we,
    input  logic                  dp_lock,
    input  logic [ADDR_RANGE-1:0] dp_addr,
    input  logic [DATA_RANGE-1:0] dp_wdata,
    output logic                  dp_gnt,
    output logic                  dp_rvalid,
    output logic [DATA_RANGE-1:0] dp_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_RANGE-1:0] mem_addr,
    output logic [DATA_RANGE-1:0] mem_wdata,
    input  logic [DATA_RANGE-1:0] mem_rdata
);

    typedef enum logic {
        PREF_IF = 1'b0,
        PREF_DP = 1'b1
    } ptr_t;

    ptr_t                  ptr_q, ptr_d;
    logic                  lock_q, lock_d;
    logic                  if_elig, dp_elig;
    logic                  win_if, win_dp, locked_win;
    // Return stage: set in the cycle the read data is on mem_rdata.
    logic                  ret_valid_q;
    logic                  ret_dp_q;
    logic [DATA_RANGE-1:0] if_rdata_q, dp_rdata_q;

    always_comb begin
        // A port granted this cycle still shows its old request: mask it.
        if_elig    = if_req & ~if_gnt;
        dp_elig    = dp_req & ~dp_gnt;
        win_if     = 1'b0;
        win_dp     = 1'b0;
        locked_win = 1'b0;
        ptr_d      = ptr_q;
        lock_d     = lock_q;

        if (lock_q && dp_req) begin
            // Lock holds the memory for DP even while DP itself is masked,
            // so IF cannot slip in between two locked DP accesses.
            win_dp     = dp_elig;
            locked_win = dp_elig;
        end else if (if_elig && dp_elig) begin
            if (ptr_q == PREF_IF) win_if = 1'b1;
            else                  win_dp = 1'b1;
        end else begin
            win_if = if_elig;
            win_dp = dp_elig;
        end

        if ((win_if || win_dp) && !locked_win)
            ptr_d = win_if ? PREF_DP : PREF_IF;

        if (win_dp)
            lock_d = dp_lock;
        else if (lock_q && !dp_req)
            lock_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= PREF_IF;
            lock_q      <= 1'b0;
            if_gnt      <= 1'b0;
            dp_gnt      <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ret_valid_q <= 1'b0;
            ret_dp_q    <= 1'b0;
            if_rdata_q  <= '0;
            dp_rdata_q  <= '0;
        end else begin
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
            if_gnt <= win_if;
            dp_gnt <= win_dp;
            mem_en <= win_if | win_dp;
            if (win_if) begin
                mem_we   <= 1'b0;
                mem_addr <= if_addr;
            end else if (win_dp) begin
                mem_we    <= dp_we;
                mem_addr  <= dp_addr;
                mem_wdata <= dp_wdata;
            end
            // Tag derived from the issued command: port id is dp_gnt.
            ret_valid_q <= mem_en & ~mem_we;
            ret_dp_q    <= dp_gnt;
            if (if_rvalid) if_rdata_q <= mem_rdata;
            if (dp_rvalid) dp_rdata_q <= mem_rdata;
        end
    end

    // Data is only on mem_rdata during the return cycle, so the return path
    // is combinational and the hold registers keep the value afterwards.
    assign if_rvalid = ret_valid_q & ~ret_dp_q;
    assign dp_rvalid = ret_valid_q &  ret_dp_q;
    assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
    assign dp_rdata  = dp_rvalid ? mem_rdata : dp_rdata_q;

endmodule
